// File: rtl/approx_rc_adder_pipe.sv
// Pipelined WIDTH-bit ripple-carry adder: the low k bits use approximate cell 113, the rest are
// exact. A built-in monitor accumulates error statistics against the exact sum.
module approx_rc_adder_pipe #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned APPROX_MAX = 8,
    parameter int unsigned STAGES     = 2,
    parameter int unsigned ACC_W      = 32,
    localparam int unsigned KW        = $clog2(APPROX_MAX + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in1,
    input  logic [WIDTH-1:0] i_in2,
    input  logic [KW-1:0]    i_approx_k,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH:0]   o_sum,
    output logic [WIDTH:0]   o_exact_sum,
    input  logic             i_stat_clear,
    output logic [ACC_W-1:0] o_err_acc,
    output logic [WIDTH:0]   o_err_max,
    output logic [ACC_W-1:0] o_sample_cnt
);

    localparam logic [KW-1:0] KMax = KW'(APPROX_MAX);
    localparam int unsigned   SumW = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;

    // First bit of segment j; the first WIDTH % STAGES segments get one extra bit.
    function automatic int seg_lo(input int j);
        int base;
        int rem;
        base = int'(WIDTH / STAGES);
        rem  = int'(WIDTH % STAGES);
        return j * base + ((j < rem) ? j : rem);
    endfunction

    logic          w_adv;
    logic [KW-1:0] w_k_clamped;

    assign w_k_clamped = (i_approx_k > KMax) ? KMax : i_approx_k;

    for (genvar j = 0; j < STAGES; j++) begin : g_stage
        localparam int Lo = seg_lo(j);
        localparam int Hi = seg_lo(j + 1);

        logic [WIDTH-1:0] w_a, w_b, w_s_in, w_x_in, w_s, w_x;
        logic [KW-1:0]    w_k;
        logic             w_v_in, w_c_in, w_xc_in, w_c, w_xc;
        logic [WIDTH-1:0] r_s, r_x;
        logic             r_v, r_c, r_xc;

        if (j == 0) begin : g_src
            assign w_a     = i_in1;
            assign w_b     = i_in2;
            assign w_k     = w_k_clamped;
            assign w_v_in  = i_in_valid;
            assign w_s_in  = '0;
            assign w_x_in  = '0;
            assign w_c_in  = 1'b0;
            assign w_xc_in = 1'b0;
        end else begin : g_src
            assign w_a     = g_stage[j-1].g_fwd.r_a;
            assign w_b     = g_stage[j-1].g_fwd.r_b;
            assign w_k     = g_stage[j-1].g_fwd.r_k;
            assign w_v_in  = g_stage[j-1].r_v;
            assign w_s_in  = g_stage[j-1].r_s;
            assign w_x_in  = g_stage[j-1].r_x;
            assign w_c_in  = g_stage[j-1].r_c;
            assign w_xc_in = g_stage[j-1].r_xc;
        end

        // Approximate and exact carry chains ripple side by side through this segment.
        always_comb begin
            w_s  = w_s_in;
            w_x  = w_x_in;
            w_c  = w_c_in;
            w_xc = w_xc_in;
            for (int i = Lo; i < Hi; i++) begin
                if (i < int'(w_k)) begin
                    w_s[i] = (~w_a[i] & (w_b[i] | w_c)) | (w_a[i] & w_b[i] & w_c);
                    w_c    = w_a[i];
                end else begin
                    w_s[i] = w_a[i] ^ w_b[i] ^ w_c;
                    w_c    = (w_a[i] & w_b[i]) | (w_c & (w_a[i] ^ w_b[i]));
                end
                w_x[i] = w_a[i] ^ w_b[i] ^ w_xc;
                w_xc   = (w_a[i] & w_b[i]) | (w_xc & (w_a[i] ^ w_b[i]));
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_v  <= 1'b0;
                r_s  <= '0;
                r_x  <= '0;
                r_c  <= 1'b0;
                r_xc <= 1'b0;
            end else if (w_adv) begin
                r_v  <= w_v_in;
                r_s  <= w_s;
                r_x  <= w_x;
                r_c  <= w_c;
                r_xc <= w_xc;
            end
        end

        if (j < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] r_a, r_b;
            logic [KW-1:0]    r_k;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_a <= '0;
                    r_b <= '0;
                    r_k <= '0;
                end else if (w_adv) begin
                    r_a <= w_a;
                    r_b <= w_b;
                    r_k <= w_k;
                end
            end
        end
    end

    assign o_out_valid = g_stage[STAGES-1].r_v;
    assign o_sum       = {g_stage[STAGES-1].r_c, g_stage[STAGES-1].r_s};
    assign o_exact_sum = {g_stage[STAGES-1].r_xc, g_stage[STAGES-1].r_x};
    assign w_adv       = ~o_out_valid | i_out_ready;
    assign o_in_ready  = w_adv;

    logic             w_xfer;
    logic [WIDTH+1:0] w_diff, w_abs;
    logic [WIDTH:0]   w_err;
    logic [SumW-1:0]  w_acc_sum;
    logic [ACC_W-1:0] w_acc_next;
    logic [ACC_W-1:0] r_err_acc, r_sample_cnt;
    logic [WIDTH:0]   r_err_max;

    assign w_xfer     = o_out_valid & i_out_ready;
    assign w_diff     = {1'b0, o_exact_sum} - {1'b0, o_sum};
    assign w_abs      = w_diff[WIDTH+1] ? (~w_diff + 1'b1) : w_diff;
    assign w_err      = w_abs[WIDTH:0];
    assign w_acc_sum  = SumW'(r_err_acc) + SumW'(w_err);
    assign w_acc_next = (|w_acc_sum[SumW-1:ACC_W]) ? '1 : w_acc_sum[ACC_W-1:0];

    // A clear on the same edge as a transfer drops that sample.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_stat_clear) begin
            r_err_acc    <= '0;
            r_err_max    <= '0;
            r_sample_cnt <= '0;
        end else if (w_xfer) begin
            r_err_acc    <= w_acc_next;
            r_sample_cnt <= (&r_sample_cnt) ? r_sample_cnt : r_sample_cnt + 1'b1;
            if (w_err > r_err_max) begin
                r_err_max <= w_err;
            end
        end
    end

    assign o_err_acc    = r_err_acc;
    assign o_err_max    = r_err_max;
    assign o_sample_cnt = r_sample_cnt;

endmodule
